// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK drive sequencer: op encodings, FSM states and
// the JK next-state rule used by the reference model.
package jk_seq_pkg;

    localparam int unsigned OP_W = 2;

    localparam logic [OP_W-1:0] OP_HOLD = 2'b00;
    localparam logic [OP_W-1:0] OP_RST  = 2'b01;
    localparam logic [OP_W-1:0] OP_SET  = 2'b10;
    localparam logic [OP_W-1:0] OP_TGL  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    function automatic logic jk_next(input logic [OP_W-1:0] op, input logic q);
        case (op)
            OP_RST:  return 1'b0;
            OP_SET:  return 1'b1;
            OP_TGL:  return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/jk_drive_sequencer_if.sv
// Command handshake into the JK drive sequencer: valid/ready plus op and repeat count.
interface jk_drive_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; read/write pointers carry an extra wrap bit so
// full and empty are distinguished without an occupancy counter.
module jk_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Drives queued JK ops onto a flip-flop stage, tracks the expected Q and flags
// any disagreement with the returned q after a settle pipeline.
module jk_drive_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    jk_drive_sequencer_if.slave   cmd,
    output logic                  j,
    output logic                  k,
    input  logic                  q_in,
    output logic                  q_expect,
    output logic                  busy,
    output logic                  op_done,
    output logic                  mismatch,
    input  logic                  clr_err
);
    localparam int unsigned W = OP_W + CNT_W;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [W-1:0]     fifo_dout;

    state_e           state_q;
    logic [OP_W-1:0]  op_q;
    logic [CNT_W-1:0] rem_q;
    logic             j_q;
    logic             k_q;
    logic             op_done_q;
    logic             q_exp_q;
    logic             known_q;
    logic             mismatch_q;
    logic [SETTLE-1:0] exp_pipe_q;
    logic [SETTLE-1:0] known_pipe_q;
    logic [SETTLE-1:0] qin_pipe_q;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd.cmd_valid),
        .pop   (fifo_pop),
        .din   ({cmd.cmd_op, cmd.cmd_count}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd.cmd_ready = !fifo_full;

    // Pop from IDLE, or in the final drive cycle so the next op follows with no bubble.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || (rem_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_HOLD;
            rem_q     <= '0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            op_done_q <= 1'b0;
        end else begin
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            op_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op_q    <= fifo_dout[W-1 -: OP_W];
                        rem_q   <= fifo_dout[CNT_W-1:0];
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    j_q   <= op_q[1];
                    k_q   <= op_q[0];
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == '0) begin
                        op_done_q <= 1'b1;
                        if (!fifo_empty) begin
                            op_q  <= fifo_dout[W-1 -: OP_W];
                            rem_q <= fifo_dout[CNT_W-1:0];
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Model follows the levels the flop sees; j=k=0 outside DRIVE holds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_exp_q <= 1'b0;
            known_q <= 1'b0;
        end else begin
            q_exp_q <= jk_next({j_q, k_q}, q_exp_q);
            known_q <= known_q | (j_q ^ k_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_pipe_q   <= '0;
            known_pipe_q <= '0;
            qin_pipe_q   <= '0;
        end else begin
            exp_pipe_q[0]   <= q_exp_q;
            known_pipe_q[0] <= known_q;
            qin_pipe_q[0]   <= q_in;
            for (int unsigned i = 1; i < SETTLE; i++) begin
                exp_pipe_q[i]   <= exp_pipe_q[i-1];
                known_pipe_q[i] <= known_pipe_q[i-1];
                qin_pipe_q[i]   <= qin_pipe_q[i-1];
            end
        end
    end

    // Sticky error; a fresh mismatch overrides a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (known_pipe_q[SETTLE-1] &&
                     (exp_pipe_q[SETTLE-1] != qin_pipe_q[SETTLE-1])) begin
            mismatch_q <= 1'b1;
        end else if (clr_err) begin
            mismatch_q <= 1'b0;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign op_done  = op_done_q;
    assign q_expect = q_exp_q;
    assign mismatch = mismatch_q;
    assign busy     = (state_q == ST_DRIVE) || !fifo_empty;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Bench for jk_drive_sequencer: directed and randomized op sequences checked
// against a queue-based expectation of the drive stream and Q trajectory.
module tb_jk_drive_sequencer;
    import jk_seq_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SETTLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_err = 1'b0;
    logic q_in;
    logic jo, ko, q_expect, busy, op_done, mismatch;

    int checks   = 0;
    int failures = 0;
    int q_mode   = 0;   // 0 flop model, 1 tied 0, 2 random, 3 tied 1

    logic q_ff = 1'($urandom);
    logic q_rand = 1'b0;
    int   done_cnt = 0;
    int   jhi_cnt  = 0;
    int   khi_cnt  = 0;

    jk_drive_sequencer_if #(.CNT_W(CNT_W)) cmd_if ();

    jk_drive_sequencer #(
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if),
        .j        (jo),
        .k        (ko),
        .q_in     (q_in),
        .q_expect (q_expect),
        .busy     (busy),
        .op_done  (op_done),
        .mismatch (mismatch),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    // Behavioural JK flop standing in for the gate-level stage (never reset).
    always @(posedge clk) begin
        if (jo && !ko)      q_ff <= 1'b1;
        else if (!jo && ko) q_ff <= 1'b0;
        else if (jo && ko)  q_ff <= ~q_ff;
        q_rand <= 1'($urandom);
    end

    assign q_in = (q_mode == 1) ? 1'b0 :
                  (q_mode == 2) ? q_rand :
                  (q_mode == 3) ? 1'b1 : q_ff;

    always @(posedge clk) begin
        if (rst) begin
            done_cnt <= 0;
            jhi_cnt  <= 0;
            khi_cnt  <= 0;
        end else begin
            if (op_done) done_cnt <= done_cnt + 1;
            if (jo)      jhi_cnt  <= jhi_cnt + 1;
            if (ko)      khi_cnt  <= khi_cnt + 1;
        end
    end

    function automatic logic ref_q(input logic [1:0] op, input logic q);
        if (op == OP_SET) return 1'b1;
        if (op == OP_RST) return 1'b0;
        if (op == OP_TGL) return !q;
        return q;
    endfunction

    task automatic drive_cmd(input logic v, input logic [1:0] op, input int cnt);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_count = CNT_W'(cnt);
    endtask

    task automatic do_reset(input int mode);
        @(negedge clk);
        rst = 1'b1;
        clr_err = 1'b0;
        q_mode = mode;
        drive_cmd(1'b0, OP_HOLD, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(0);
        checks += 6;
        if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset cmd_ready: got %b expected 1", cmd_if.cmd_ready); end
        if ({jo, ko} !== 2'b00) begin failures++; $display("FAIL reset jk: got %b expected 00", {jo, ko}); end
        if (q_expect !== 1'b0) begin failures++; $display("FAIL reset q_expect: got %b expected 0", q_expect); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy); end
        if (op_done !== 1'b0) begin failures++; $display("FAIL reset op_done: got %b expected 0", op_done); end
        if (mismatch !== 1'b0) begin failures++; $display("FAIL reset mismatch: got %b expected 0", mismatch); end
    endtask

    // Directed single/back-to-back sequences followed by random batches.
    task automatic test_sequences();
        logic [1:0] c_op[$];
        int         c_cnt[$];
        logic [1:0] e_jk[$];
        logic       e_done[$];
        int         n, total, i;
        logic [1:0] ejk;
        logic       edone, qm;
        for (int s = 0; s < 10; s++) begin
            c_op.delete(); c_cnt.delete(); e_jk.delete(); e_done.delete();
            if (s == 0) begin
                c_op.push_back(OP_SET); c_cnt.push_back(0);
            end else if (s == 1) begin
                c_op.push_back(OP_SET); c_cnt.push_back(0);
                c_op.push_back(OP_TGL); c_cnt.push_back(3);
                c_op.push_back(OP_RST); c_cnt.push_back(1);
            end else begin
                n = int'($urandom_range(4, 1));
                for (int c = 0; c < n; c++) begin
                    c_op.push_back(2'($urandom_range(3, 0)));
                    c_cnt.push_back(int'($urandom_range(4, 0)));
                end
            end
            n = c_op.size();
            foreach (c_op[c]) begin
                for (int r = 0; r <= c_cnt[c]; r++) begin
                    e_jk.push_back(c_op[c]);
                    e_done.push_back(r == c_cnt[c]);
                end
            end
            total = e_jk.size();
            do_reset(0);
            qm = 1'b0;
            for (int cyc = 0; cyc < total + n + 6; cyc++) begin
                @(negedge clk);
                if (cyc >= 3) begin
                    i = cyc - 3;
                    ejk   = (i < total) ? e_jk[i] : 2'b00;
                    edone = (i < total) ? e_done[i] : 1'b0;
                    checks += 4;
                    if ({jo, ko} !== ejk) begin failures++; $display("FAIL seq%0d jk[%0d]: got %b expected %b", s, i, {jo, ko}, ejk); end
                    if (op_done !== edone) begin failures++; $display("FAIL seq%0d op_done[%0d]: got %b expected %b", s, i, op_done, edone); end
                    if (q_expect !== qm) begin failures++; $display("FAIL seq%0d q_expect[%0d]: got %b expected %b", s, i, q_expect, qm); end
                    if (busy !== (i <= total - 2)) begin failures++; $display("FAIL seq%0d busy[%0d]: got %b expected %b", s, i, busy, (i <= total - 2)); end
                    if (i < total) qm = ref_q(e_jk[i], qm);
                end
                if (cyc < n) drive_cmd(1'b1, c_op[cyc], c_cnt[cyc]);
                else         drive_cmd(1'b0, OP_HOLD, 0);
            end
            checks++;
            if (mismatch !== 1'b0) begin failures++; $display("FAIL seq%0d mismatch: got %b expected 0", s, mismatch); end
        end
    endtask

    task automatic test_fifo_full();
        do_reset(0);
        drive_cmd(1'b1, OP_HOLD, 20);
        @(negedge clk); drive_cmd(1'b0, OP_HOLD, 0);
        @(negedge clk);
        for (int c = 0; c < int'(DEPTH); c++) begin
            drive_cmd(1'b1, OP_SET, 0);
            @(negedge clk);
        end
        checks++;
        if (cmd_if.cmd_ready !== 1'b0) begin failures++; $display("FAIL full cmd_ready: got %b expected 0", cmd_if.cmd_ready); end
        drive_cmd(1'b1, OP_RST, 0);
        @(negedge clk); drive_cmd(1'b0, OP_HOLD, 0);
        repeat (60) @(negedge clk);
        checks += 5;
        if (done_cnt != int'(DEPTH) + 1) begin failures++; $display("FAIL full op_count: got %0d expected %0d", done_cnt, DEPTH + 1); end
        if (jhi_cnt != int'(DEPTH)) begin failures++; $display("FAIL full set_cycles: got %0d expected %0d", jhi_cnt, DEPTH); end
        if (khi_cnt != 0) begin failures++; $display("FAIL full rst_cycles: got %0d expected 0", khi_cnt); end
        if (q_expect !== 1'b1) begin failures++; $display("FAIL full q_expect: got %b expected 1", q_expect); end
        if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL full drain: got ready=%b busy=%b expected 1 0", cmd_if.cmd_ready, busy); end
    endtask

    task automatic test_max_count();
        logic seen;
        int   maxc;
        maxc = (1 << CNT_W) - 1;
        seen = 1'b0;
        do_reset(0);
        drive_cmd(1'b1, OP_SET, maxc);
        @(negedge clk); drive_cmd(1'b0, OP_HOLD, 0);
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (op_done) seen = 1'b1;
        end
        @(negedge clk);
        checks += 3;
        if (!seen) begin failures++; $display("FAIL maxcnt op_done: got none expected pulse within 400 cycles"); end
        if (jhi_cnt != maxc + 1) begin failures++; $display("FAIL maxcnt cycles: got %0d expected %0d", jhi_cnt, maxc + 1); end
        if (done_cnt != 1) begin failures++; $display("FAIL maxcnt done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_mismatch();
        do_reset(1);
        drive_cmd(1'b1, OP_SET, 0);
        @(negedge clk); drive_cmd(1'b0, OP_HOLD, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({jo, ko} !== 2'b10) begin failures++; $display("FAIL mm drive: got %b expected 10", {jo, ko}); end
        for (int c = 1; c <= int'(SETTLE) + 2; c++) begin
            @(negedge clk);
            if (c == int'(SETTLE) + 1) begin
                checks++;
                if (mismatch !== 1'b0) begin failures++; $display("FAIL mm early: got %b expected 0", mismatch); end
            end
            if (c == int'(SETTLE) + 2) begin
                checks++;
                if (mismatch !== 1'b1) begin failures++; $display("FAIL mm set: got %b expected 1", mismatch); end
            end
        end
        q_mode = 3;
        repeat (SETTLE + 3) @(negedge clk);
        checks++;
        if (mismatch !== 1'b1) begin failures++; $display("FAIL mm sticky: got %b expected 1", mismatch); end
        clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        checks++;
        if (mismatch !== 1'b0) begin failures++; $display("FAIL mm clear: got %b expected 0", mismatch); end
        q_mode = 1;
        repeat (SETTLE + 2) @(negedge clk);
        checks++;
        if (mismatch !== 1'b1) begin failures++; $display("FAIL mm reerror: got %b expected 1", mismatch); end
        clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        checks++;
        if (mismatch !== 1'b1) begin failures++; $display("FAIL mm set_wins: got %b expected 1", mismatch); end
    endtask

    task automatic test_unknown();
        do_reset(2);
        drive_cmd(1'b1, OP_TGL, 5);
        @(negedge clk); drive_cmd(1'b0, OP_HOLD, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (mismatch !== 1'b0) begin failures++; $display("FAIL unknown mismatch[%0d]: got %b expected 0", c, mismatch); end
        end
        checks++;
        if (q_expect !== 1'b0) begin failures++; $display("FAIL unknown q_expect: got %b expected 0", q_expect); end
    endtask

    task automatic test_rst_mid_op();
        do_reset(0);
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (cyc == 5) begin
                checks++;
                if ({jo, ko} !== 2'b11) begin failures++; $display("FAIL rstmid drive: got %b expected 11", {jo, ko}); end
                rst = 1'b1;
            end
            if (cyc == 0)      drive_cmd(1'b1, OP_TGL, 9);
            else if (cyc == 1) drive_cmd(1'b1, OP_SET, 2);
            else if (cyc == 2) drive_cmd(1'b1, OP_RST, 1);
            else               drive_cmd(1'b0, OP_HOLD, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        checks += 5;
        if ({jo, ko} !== 2'b00) begin failures++; $display("FAIL rstmid jk: got %b expected 00", {jo, ko}); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid busy: got %b expected 0", busy); end
        if (q_expect !== 1'b0) begin failures++; $display("FAIL rstmid q_expect: got %b expected 0", q_expect); end
        if (op_done !== 1'b0) begin failures++; $display("FAIL rstmid op_done: got %b expected 0", op_done); end
        if (cmd_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid cmd_ready: got %b expected 1", cmd_if.cmd_ready); end
        repeat (20) @(negedge clk);
        checks += 2;
        if (done_cnt != 0) begin failures++; $display("FAIL rstmid later_ops: got %0d expected 0", done_cnt); end
        if (jhi_cnt + khi_cnt != 0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid quiet: got j=%0d k=%0d busy=%b expected 0 0 0", jhi_cnt, khi_cnt, busy); end
    endtask

    initial begin
        drive_cmd(1'b0, OP_HOLD, 0);
        test_reset();
        test_sequences();
        test_fifo_full();
        test_max_count();
        test_mismatch();
        test_unknown();
        test_rst_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
